// File: rtl/jbcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder.
package jbcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_ADJ = 4'd6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/jbcd_digit_add.sv
// Single-digit BCD add cell: binary add, then +6 correction when the
// raw sum leaves the decimal range.
module jbcd_digit_add
    import jbcd_pkg::*;
(
    input  bcd_digit_t x,
    input  bcd_digit_t y,
    input  logic       ci,
    output bcd_digit_t digit,
    output logic       co,
    output logic       inv
);

    logic [4:0] rawSum;

    // Invalid digits still go through the same correction so the result is deterministic.
    always_comb begin
        rawSum = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
        co     = (rawSum > {1'b0, BCD_MAX});
        digit  = co ? (rawSum[3:0] + BCD_ADJ) : rawSum[3:0];
        inv    = (x > BCD_MAX) || (y > BCD_MAX);
    end

endmodule

// File: rtl/jbcd_serial_adder.sv
// Multi-digit packed-BCD adder working one digit per clock, LSD first,
// with a start/busy/done handshake and a registered result.
module jbcd_serial_adder
    import jbcd_pkg::*;
#(
    parameter int DIGITS = 4
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(1);

    state_t           state_q;
    logic [W-1:0]     opA_q;
    logic [W-1:0]     opB_q;
    logic [W-1:0]     sum_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             cout_q;
    logic             err_q;
    logic             busy_q;
    logic             done_q;

    logic [IDX_W+1:0] bitBase;
    bcd_digit_t       digA;
    bcd_digit_t       digB;
    bcd_digit_t       digit_d;
    logic             carry_d;
    logic             inv_d;

    assign bitBase = {idx_q, 2'b00};
    assign digA    = opA_q[bitBase +: 4];
    assign digB    = opB_q[bitBase +: 4];

    jbcd_digit_add uDigit (
        .x     (digA),
        .y     (digB),
        .ci    (carry_q),
        .digit (digit_d),
        .co    (carry_d),
        .inv   (inv_d)
    );

    // Operands are captured at acceptance so later input changes cannot disturb the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        opA_q   <= a;
                        opB_q   <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[bitBase +: 4] <= digit_d;
                    carry_q             <= carry_d;
                    err_q               <= err_q | inv_d;
                    idx_q               <= idx_q + IDX_STEP;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= carry_d;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_jbcd_serial_adder.sv
// Directed self-checking bench for jbcd_serial_adder (DIGITS=4); inputs
// are driven and outputs sampled on the falling edge.
module tb_jbcd_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    int testCount = 0;
    int failCount = 0;

    jbcd_serial_adder #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Starts one operation from the current falling edge and waits (bounded) for done.
    task automatic applyStimulus(input logic [15:0] aV, input logic [15:0] bV, input logic cV,
                                 input bit interfere, output int latency, output int busyCycles);
        a     = aV;
        b     = bV;
        cin   = cV;
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        latency    = 1;
        busyCycles = 0;
        while (!done && latency < 20) begin
            if (busy) busyCycles++;
            if (interfere && latency == 2) begin
                start = 1'b1;
                a     = 16'h5555;
                b     = 16'h5555;
            end else if (interfere && latency == 3) begin
                start = 1'b0;
                a     = 16'h7777;
                b     = 16'h3333;
                cin   = 1'b1;
            end
            @(negedge clk);
            latency++;
        end
    endtask

    task automatic runOp(input string name, input logic [15:0] aV, input logic [15:0] bV,
                         input logic cV, input bit interfere, input logic [15:0] expSum,
                         input logic expCout, input logic expErr);
        int lat;
        int bc;
        applyStimulus(aV, bV, cV, interfere, lat, bc);
        checkOutput({name, ".latency"}, lat, 5);
        checkOutput({name, ".busyCycles"}, bc, 4);
        checkOutput({name, ".done"}, done, 1);
        checkOutput({name, ".sum"}, sum, expSum);
        checkOutput({name, ".cout"}, cout, expCout);
        checkOutput({name, ".err"}, err, expErr);
        @(negedge clk);
        checkOutput({name, ".doneWidth"}, done, 0);
        checkOutput({name, ".busyIdle"}, busy, 0);
        checkOutput({name, ".sumHeld"}, sum, expSum);
        checkOutput({name, ".coutHeld"}, cout, expCout);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.done", done, 0);
        checkOutput("reset.sum", sum, 0);
        checkOutput("reset.cout", cout, 0);
        checkOutput("reset.err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        runOp("zero",       16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        runOp("mixed",      16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
        runOp("ripple",     16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        runOp("maxCarry",   16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0);
        runOp("invalid",    16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1);
        runOp("afterErr",   16'h0005, 16'h0004, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0);
        runOp("ignore",     16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
        runOp("backToBack", 16'h4321, 16'h1234, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        // Two digits in (4+8 -> 2 c1, A+7+1 -> 8 c1, invalid), then reset mid-run.
        a     = 16'h12A4;
        b     = 16'h5678;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midRun.busy", busy, 1);
        checkOutput("midRun.partialSum", sum, 16'h0082);
        checkOutput("midRun.err", err, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("asyncReset.busy", busy, 0);
        checkOutput("asyncReset.done", done, 0);
        checkOutput("asyncReset.sum", sum, 0);
        checkOutput("asyncReset.cout", cout, 0);
        checkOutput("asyncReset.err", err, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("inReset.done", done, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("afterReset.noDone", done, 0);
        end
        runOp("postReset", 16'h0050, 16'h0050, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
